rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: the ALU (single-cycle results) and the LSU (variable-latency load data).
- Keeps a pending-write scoreboard so the issue stage can stall on RAW hazards against in-flight destinations.
- Sits between the execute/memory stages and the register file's write port (rf_en/rd/wdata). Drives that port from a registered output stage.

Parameters:
- XLEN, 32, data width of writeback values
- NREGS, 32, number of architectural registers; index width AW = clog2(NREGS) = 5
- STARVE_LIMIT, 4, consecutive denied cycles after which the ALU is forced a grant over the LSU

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU writeback request
- alu_rd  in  AW  ALU destination register
- alu_wdata  in  XLEN  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- lsu_valid  in  1  LSU writeback request
- lsu_rd  in  AW  LSU destination register
- lsu_wdata  in  XLEN  load data
- lsu_ready  out  1  LSU request accepted this cycle
- iss_set  in  1  issue stage marks iss_rd as pending
- iss_rd  in  AW  destination being issued
- rs1, rs2  in  AW  source registers queried by issue stage
- rs1_busy, rs2_busy  out  1  source has an outstanding write
- rf_en  out  1  register-file write enable
- rf_rd  out  AW  register-file write address
- rf_wdata  out  XLEN  register-file write data

Behaviour:
- Reset (async, rst_n=0): rf_en=0, rf_rd=0, rf_wdata=0, scoreboard all 0, starve counter 0. alu_ready/lsu_ready are 0 while rst_n=0. Reset mid-request drops any accepted-but-unwritten result; requesters re-present after reset.
- Handshake: a transfer occurs when valid && ready in the same cycle. ready is combinational from valid and the starve counter; it never depends on ready. At most one of alu_ready/lsu_ready is 1 per cycle. A requester holds valid/rd/wdata stable until accepted.
- Arbitration:
  - Only one valid: that one is granted.
  - Both valid: LSU is granted unless starve_cnt == STARVE_LIMIT, in which case ALU is granted.
- Starve counter:
  - Increments each cycle alu_valid=1 and ALU is not granted.
  - Clears when ALU is granted or alu_valid=0.
  - Saturates at STARVE_LIMIT.
- Output stage, 1-cycle latency: on the edge after a grant, rf_en=1, rf_rd/rf_wdata = granted request's rd/wdata. With no grant, rf_en=0 and rf_rd/rf_wdata hold their last values. Back-to-back grants give rf_en high on consecutive cycles.
- rd == 0 grants: the handshake completes normally but rf_en stays 0 for that slot.
- Scoreboard, NREGS bits; bit 0 is hardwired 0:
  - Set at clock edge when iss_set=1 and iss_rd != 0.
  - Cleared at clock edge when rf_en=1, for bit rf_rd (the same edge the register file writes).
  - Simultaneous set and clear of the same index: set wins, because a newer producer is issued.
  - Sets and clears of different indices both take effect.
- Busy query: combinational. rsN_busy = scoreboard[rsN]; always 0 for rsN == 0.
  - busy drops the cycle after rf_en pulses, when the register file's asynchronous read already returns the new value. No bypass is needed.
  - Same-cycle iss_set is not reflected in busy until the next cycle.
- No internal buffering beyond the output register; throughput is one write per cycle.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with alu_valid=1 -> rf_en, rf_rd, rf_wdata, alu_ready, rsN_busy all 0 immediately. After release, first grant appears on rf_* exactly 1 cycle after handshake.
- Single requester: alu_valid=1, alu_rd=5, alu_wdata=0xDEADBEEF -> alu_ready=1 same cycle. Next cycle rf_en=1, rf_rd=5, rf_wdata=0xDEADBEEF. Following cycle rf_en=0.
- Contention/starvation: both valid continuously, lsu_rd cycling 1..7, alu_rd=9 -> LSU granted 4 cycles, ALU granted on cycle 5 (starve_cnt==4), then LSU again. Counter restarts from 0.
- Scoreboard: iss_set with iss_rd=7; next cycle rs1=7 -> rs1_busy=1. LSU writes rd=7 -> busy stays 1 during the rf_en cycle and reads 0 the cycle after.
- Set/clear collision: rf_en=1, rf_rd=3 on the same edge as iss_set with iss_rd=3 -> scoreboard[3] remains 1.
- x0 handling: iss_set with iss_rd=0 and an ALU request with alu_rd=0 -> rs1=0 busy is always 0. Handshake completes with alu_ready=1, and rf_en is never asserted.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: shares one write port between ALU and LSU,
// and tracks in-flight destinations in a pending-write scoreboard.
module rf_wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int NREGS        = 32,
  parameter int STARVE_LIMIT = 4,
  localparam int AW          = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_wdata,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_wdata,
  output logic            lsu_ready,
  input  logic            iss_set,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rf_en,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_wdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == SW'(STARVE_LIMIT)) ? v : v + 1'b1;
  endfunction

  logic [SW-1:0]   starve_cnt;
  logic            starve_hit;
  logic            alu_gnt;
  logic            lsu_gnt;
  logic            vld_p0;
  logic [AW-1:0]   rd_p0;
  logic [XLEN-1:0] wdata_p0;
  logic            vld_p1;
  logic [AW-1:0]   rd_p1;
  logic [XLEN-1:0] wdata_p1;
  logic [NREGS-1:0] sb_q;
  logic [NREGS-1:0] sb_d;

  // Stage p0: arbitration and grant mux
  always_comb begin
    starve_hit = (starve_cnt == SW'(STARVE_LIMIT));
    alu_gnt    = rst_n & alu_valid & (~lsu_valid | starve_hit);
    lsu_gnt    = rst_n & lsu_valid & ~(alu_valid & starve_hit);
    rd_p0      = alu_gnt ? alu_rd    : lsu_rd;
    wdata_p0   = alu_gnt ? alu_wdata : lsu_wdata;
    // x0 writes complete the handshake but never reach the register file
    vld_p0     = (alu_gnt | lsu_gnt) & (rd_p0 != '0);
  end

  assign alu_ready = alu_gnt;
  assign lsu_ready = lsu_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (alu_valid && !alu_gnt) begin
      starve_cnt <= sat_inc(starve_cnt);
    end else begin
      starve_cnt <= '0;
    end
  end

  // Stage p1: registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      rd_p1    <= '0;
      wdata_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        rd_p1    <= rd_p0;
        wdata_p1 <= wdata_p0;
      end
    end
  end

  assign rf_en    = vld_p1;
  assign rf_rd    = rd_p1;
  assign rf_wdata = wdata_p1;

  // A newer issue to the same register outranks the retiring write
  always_comb begin
    sb_d = sb_q;
    if (vld_p1) sb_d[rd_p1] = 1'b0;
    if (iss_set && (iss_rd != '0)) sb_d[iss_rd] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_q <= '0;
    else        sb_q <= sb_d;
  end

  assign rs1_busy = sb_q[rs1];
  assign rs2_busy = sb_q[rs2];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized plus directed bench for rf_wb_arbiter against a behavioural model.
module tb_rf_wb_arbiter;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int STARVE_LIMIT = 4;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            alu_valid, lsu_valid, iss_set;
  logic [AW-1:0]   alu_rd, lsu_rd, iss_rd, rs1, rs2;
  logic [XLEN-1:0] alu_wdata, lsu_wdata;
  logic            alu_ready, lsu_ready, rs1_busy, rs2_busy, rf_en;
  logic [AW-1:0]   rf_rd;
  logic [XLEN-1:0] rf_wdata;

  int checks = 0;
  int failures = 0;

  // behavioural model state
  int          m_starve;
  bit          m_pend [NREGS];
  bit          m_en;
  int          m_rd;
  logic [31:0] m_wd;
  bit          m_ga, m_gl;
  bit          last_ga, last_gl;

  rf_wb_arbiter #(.XLEN(XLEN), .NREGS(NREGS), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wdata(alu_wdata), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_wdata(lsu_wdata), .lsu_ready(lsu_ready),
    .iss_set(iss_set), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_en(rf_en), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_starve = 0;
    m_en = 0;
    m_rd = 0;
    m_wd = '0;
    last_ga = 0;
    last_gl = 0;
    for (int i = 0; i < NREGS; i++) m_pend[i] = 0;
  endtask

  // One clock: called at a negedge with inputs already applied.
  task automatic cycle();
    #1;
    m_ga = alu_valid && (!lsu_valid || m_starve >= STARVE_LIMIT);
    m_gl = lsu_valid && !m_ga;
    chk("alu_ready", alu_ready, m_ga);
    chk("lsu_ready", lsu_ready, m_gl);
    chk("rs1_busy", rs1_busy, (rs1 != 0) && m_pend[rs1]);
    chk("rs2_busy", rs2_busy, (rs2 != 0) && m_pend[rs2]);
    @(posedge clk);
    if (m_en) m_pend[m_rd] = 0;
    if (iss_set && iss_rd != 0) m_pend[iss_rd] = 1;
    if (alu_valid && !m_ga) m_starve = (m_starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_starve + 1;
    else m_starve = 0;
    m_en = 0;
    if (m_ga && alu_rd != 0) begin m_en = 1; m_rd = alu_rd; m_wd = alu_wdata; end
    if (m_gl && lsu_rd != 0) begin m_en = 1; m_rd = lsu_rd; m_wd = lsu_wdata; end
    last_ga = m_ga;
    last_gl = m_gl;
    @(negedge clk);
    chk("rf_en", rf_en, m_en);
    if (m_en) begin
      chk("rf_rd", rf_rd, m_rd);
      chk("rf_wdata", rf_wdata, m_wd);
    end
  endtask

  task automatic idle_inputs();
    alu_valid = 0; lsu_valid = 0; iss_set = 0;
    alu_rd = '0; lsu_rd = '0; iss_rd = '0; rs1 = '0; rs2 = '0;
    alu_wdata = '0; lsu_wdata = '0;
  endtask

  initial begin
    logic [5:0] pat;
    rst_n = 0;
    idle_inputs();
    alu_valid = 1; alu_rd = 5'd3; alu_wdata = 32'h1234_5678;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_alu_ready", alu_ready, 1'b0);
    chk("rst_rf_en", rf_en, 1'b0);
    chk("rst_rf_rd", rf_rd, 5'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1;

    // single ALU requester
    alu_valid = 1; alu_rd = 5'd5; alu_wdata = 32'hDEADBEEF;
    cycle();
    chk("single_rd", rf_rd, 5'd5);
    chk("single_wd", rf_wdata, 32'hDEADBEEF);
    idle_inputs();
    cycle();
    chk("single_en_drop", rf_en, 1'b0);

    // contention and starvation
    alu_valid = 1; alu_rd = 5'd9; alu_wdata = 32'h0000_0099;
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      lsu_valid = 1; lsu_rd = AW'(i + 1); lsu_wdata = 32'hA000_0000 + i;
      cycle();
      pat[i] = last_ga;
    end
    chk("starve_pattern", pat, 6'b010000);
    idle_inputs();
    cycle();

    // scoreboard set, hold through write, drop after
    iss_set = 1; iss_rd = 5'd7;
    cycle();
    iss_set = 0; rs1 = 5'd7;
    cycle();
    chk("sb_busy_set", rs1_busy, 1'b1);
    lsu_valid = 1; lsu_rd = 5'd7; lsu_wdata = 32'h7777_0007;
    cycle();
    lsu_valid = 0;
    #1 chk("sb_busy_during_wr", rs1_busy, 1'b1);
    @(negedge clk);
    #1 chk("sb_busy_after_wr", rs1_busy, 1'b0);
    @(negedge clk);
    m_en = 0; m_pend[7] = 0;
    chk("sb_en_clear", rf_en, 1'b0);

    // set/clear collision on the same index
    alu_valid = 1; alu_rd = 5'd3; alu_wdata = 32'h3333_3333;
    cycle();
    alu_valid = 0; iss_set = 1; iss_rd = 5'd3;
    cycle();
    iss_set = 0; rs1 = 5'd3;
    #1 chk("collision_set_wins", rs1_busy, 1'b1);
    @(negedge clk);
    m_pend[3] = 1; m_en = 0;

    // x0 handling
    iss_set = 1; iss_rd = 5'd0; alu_valid = 1; alu_rd = 5'd0; alu_wdata = 32'hFFFF_FFFF; rs1 = 5'd0;
    cycle();
    chk("x0_ready", last_ga, 1'b1);
    chk("x0_no_write", rf_en, 1'b0);
    idle_inputs();
    cycle();
    chk("x0_busy", rs1_busy, 1'b0);

    // randomized traffic with hold-until-accepted requesters
    for (int n = 0; n < 400; n++) begin
      if (!(alu_valid && !last_ga)) begin
        alu_valid = ($urandom_range(0, 3) != 0);
        alu_rd = AW'($urandom_range(0, 7));
        alu_wdata = $urandom;
      end
      if (!(lsu_valid && !last_gl)) begin
        lsu_valid = ($urandom_range(0, 3) != 0);
        lsu_rd = AW'($urandom_range(0, 7));
        lsu_wdata = $urandom;
      end
      iss_set = $urandom_range(0, 1);
      iss_rd = AW'($urandom_range(0, 7));
      rs1 = AW'($urandom_range(0, 7));
      rs2 = AW'($urandom_range(0, 7));
      cycle();
    end

    // asynchronous reset while a result is in flight
    idle_inputs();
    cycle();
    iss_set = 1; iss_rd = 5'd5; alu_valid = 1; alu_rd = 5'd4; alu_wdata = 32'h1111_1111;
    cycle();
    iss_set = 0; alu_rd = 5'd6; alu_wdata = 32'h2222_2222; rs1 = 5'd5;
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_rf_en", rf_en, 1'b0);
    chk("mid_rst_rf_rd", rf_rd, 5'd0);
    chk("mid_rst_rf_wdata", rf_wdata, 32'd0);
    chk("mid_rst_alu_ready", alu_ready, 1'b0);
    chk("mid_rst_rs1_busy", rs1_busy, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    cycle();
    chk("post_rst_en", rf_en, 1'b1);
    chk("post_rst_rd", rf_rd, 5'd6);
    idle_inputs();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
